// File: rtl/led_pattern_arbiter.sv
// Shares one status LED between three blink-pattern requesters (heartbeat, activity, error).
// Fixed priority, non-preemptive: each 8-slot pattern plays fully, then a blank gap, then a done pulse.
module led_pattern_arbiter #(
  parameter int TICK_DIV  = 1500000,
  parameter int GAP_SLOTS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [7:0] pat0,
  input  logic [7:0] pat1,
  input  logic [7:0] pat2,
  output logic       led,
  output logic [2:0] grant,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam int         PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_SLOTS - 1);
  localparam bit         HAS_GAP  = (GAP_SLOTS > 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [2:0]    pending;
  logic [7:0]    pat_r0, pat_r1, pat_r2;
  logic [PW-1:0] presc;
  logic [2:0]    slot;
  logic [3:0]    gap_cnt;
  logic [7:0]    shreg;

  logic [2:0] sel_oh;
  logic [7:0] sel_pat;
  logic [2:0] clr_mask;
  logic       tick;
  logic       finish;

  assign dbg_state = state;

  // Highest pending index wins; only consulted while idle.
  always_comb begin
    sel_oh  = 3'b000;
    sel_pat = pat_r0;
    if (pending[2]) begin
      sel_oh  = 3'b100;
      sel_pat = pat_r2;
    end else if (pending[1]) begin
      sel_oh  = 3'b010;
      sel_pat = pat_r1;
    end else if (pending[0]) begin
      sel_oh  = 3'b001;
      sel_pat = pat_r0;
    end
  end

  always_comb begin
    clr_mask = (state == S_IDLE) ? sel_oh : 3'b000;
    tick     = (presc == TICK_LAST);
    finish   = tick && (((state == S_PLAY) && (slot == 3'd7) && !HAS_GAP) ||
                        ((state == S_GAP) && (gap_cnt == GAP_LAST)));
  end

  // req is a per-cycle strobe with no back-pressure: every asserted bit is captured
  // that edge, and a capture always wins over the clear of the requester being granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pending <= 3'b000;
      pat_r0  <= 8'h00;
      pat_r1  <= 8'h00;
      pat_r2  <= 8'h00;
      presc   <= '0;
      slot    <= 3'd0;
      gap_cnt <= 4'd0;
      shreg   <= 8'h00;
      led     <= 1'b0;
      grant   <= 3'b000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      pending <= (pending & ~clr_mask) | req;
      if (req[0]) pat_r0 <= pat0;
      if (req[1]) pat_r1 <= pat1;
      if (req[2]) pat_r2 <= pat2;

      case (state)
        S_IDLE: begin
          if (|pending) begin
            state <= S_PLAY;
            shreg <= sel_pat;
            grant <= sel_oh;
            presc <= '0;
            slot  <= 3'd0;
            led   <= sel_pat[0];
            busy  <= 1'b1;
          end
        end
        S_PLAY: begin
          if (tick) begin
            presc <= '0;
            slot  <= slot + 3'd1;
            shreg <= {1'b0, shreg[7:1]};
            led   <= shreg[1];
            if (slot == 3'd7 && HAS_GAP) begin
              state   <= S_GAP;
              led     <= 1'b0;
              gap_cnt <= 4'd0;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        S_GAP: begin
          if (tick) begin
            presc   <= '0;
            gap_cnt <= gap_cnt + 4'd1;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // End of pattern (+gap): one-cycle done with everything already released.
      if (finish) begin
        state <= S_DONE;
        done  <= 1'b1;
        grant <= 3'b000;
        busy  <= 1'b0;
        led   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Directed bench for led_pattern_arbiter with TICK_DIV=4, GAP_SLOTS=2.
// Observed word is {led, grant[2:0], busy, done}, sampled 1 time unit after each rising edge.
module tb_led_pattern_arbiter;

  localparam int TD = 4;
  localparam int GS = 2;
  localparam int PLAY_LEN = (8 + GS) * TD + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [7:0] pat0 = 8'h00;
  logic [7:0] pat1 = 8'h00;
  logic [7:0] pat2 = 8'h00;
  logic       led;
  logic [2:0] grant;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;
  logic [5:0] obs;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  led_pattern_arbiter #(.TICK_DIV(TD), .GAP_SLOTS(GS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .pat0      (pat0),
    .pat1      (pat1),
    .pat2      (pat2),
    .led       (led),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  assign obs = {led, grant, busy, done};

  typedef struct {
    logic [2:0] req;
    logic [7:0] p0;
    int         hold;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Checks every cycle from the grant edge through the done cycle.
  task automatic expect_playback(input logic [2:0] g, input logic [7:0] p, input string tag);
    logic [5:0] exp;
    for (int c = 0; c < PLAY_LEN; c++) begin
      step();
      if (c < 8 * TD)              exp = {p[c / TD], g, 1'b1, 1'b0};
      else if (c < (8 + GS) * TD)  exp = {1'b0, g, 1'b1, 1'b0};
      else                         exp = 6'b000001;
      check($sformatf("%s cyc%0d", tag, c), 32'(obs), 32'(exp));
    end
  endtask

  task automatic expect_idle(input string tag);
    step();
    check(tag, 32'({obs, dbg_state}), 32'(0));
  endtask

  initial begin
    // Single request, pat0 = 1010_0101, played LSB first
    vecs[0]  = '{3'b001, 8'hA5, 1, 6'b000000};
    vecs[1]  = '{3'b000, 8'h00, 4, {1'b1, 3'b001, 1'b1, 1'b0}};
    vecs[2]  = '{3'b000, 8'h00, 4, {1'b0, 3'b001, 1'b1, 1'b0}};
    vecs[3]  = '{3'b000, 8'h00, 4, {1'b1, 3'b001, 1'b1, 1'b0}};
    vecs[4]  = '{3'b000, 8'h00, 4, {1'b0, 3'b001, 1'b1, 1'b0}};
    vecs[5]  = '{3'b000, 8'h00, 4, {1'b0, 3'b001, 1'b1, 1'b0}};
    vecs[6]  = '{3'b000, 8'h00, 4, {1'b1, 3'b001, 1'b1, 1'b0}};
    vecs[7]  = '{3'b000, 8'h00, 4, {1'b0, 3'b001, 1'b1, 1'b0}};
    vecs[8]  = '{3'b000, 8'h00, 4, {1'b1, 3'b001, 1'b1, 1'b0}};
    vecs[9]  = '{3'b000, 8'h00, 8, {1'b0, 3'b001, 1'b1, 1'b0}};
    vecs[10] = '{3'b000, 8'h00, 1, 6'b000001};
    vecs[11] = '{3'b000, 8'h00, 3, 6'b000000};

    // Reset held with random requests
    for (int i = 0; i < 3; i++) begin
      req  = 3'($urandom_range(0, 7));
      pat0 = 8'($urandom_range(0, 255));
      pat1 = 8'($urandom_range(0, 255));
      pat2 = 8'($urandom_range(0, 255));
      step();
      check($sformatf("reset%0d", i), 32'(obs), 32'(0));
    end
    rst = 1'b0;
    req = 3'b000;
    expect_idle("post_reset_idle");

    // Single request table
    for (int v = 0; v < 12; v++) begin
      req  = vecs[v].req;
      pat0 = vecs[v].p0;
      for (int h = 0; h < vecs[v].hold; h++) begin
        step();
        check($sformatf("vec%0d.%0d", v, h), 32'(obs), 32'(vecs[v].exp));
        req  = 3'b000;
        pat0 = 8'h00;
      end
    end

    // Simultaneous requests served 2,1,0 from captured patterns
    req = 3'b111; pat0 = 8'h3C; pat1 = 8'h5A; pat2 = 8'h81;
    step();
    check("simul_capture", 32'(obs), 32'(0));
    req = 3'b000; pat0 = 8'hFF; pat1 = 8'hFF; pat2 = 8'hFF;
    expect_playback(3'b100, 8'h81, "simul_r2");
    expect_idle("simul_gap_a");
    expect_playback(3'b010, 8'h5A, "simul_r1");
    expect_idle("simul_gap_b");
    expect_playback(3'b001, 8'h3C, "simul_r0");
    expect_idle("simul_gap_c");
    expect_idle("simul_quiet");

    // No preemption; latest pattern for requester 2 wins
    req = 3'b001; pat0 = 8'hC6;
    step();
    req = 3'b000; pat0 = 8'h00;
    fork
      expect_playback(3'b001, 8'hC6, "nopre_r0");
      begin
        repeat (10) step();
        req = 3'b100; pat2 = 8'hFF;
        step();
        req = 3'b000; pat2 = 8'h00;
        repeat (5) step();
        req = 3'b100; pat2 = 8'h0F;
        step();
        req = 3'b000; pat2 = 8'hAA;
      end
    join
    expect_idle("nopre_gap");
    expect_playback(3'b100, 8'h0F, "nopre_r2");
    expect_idle("nopre_quiet");

    // Self re-request during own GAP replays afterwards
    req = 3'b010; pat1 = 8'h99;
    step();
    req = 3'b000; pat1 = 8'h00;
    fork
      expect_playback(3'b010, 8'h99, "self_first");
      begin
        repeat (34) step();
        req = 3'b010; pat1 = 8'h42;
        step();
        req = 3'b000; pat1 = 8'h00;
      end
    join
    expect_idle("self_gap");
    expect_playback(3'b010, 8'h42, "self_replay");
    expect_idle("self_quiet");

    // Abort in PLAY slot 4 discards pending requests
    req = 3'b001; pat0 = 8'hFF;
    step();
    req = 3'b000;
    step();
    check("abort_grant", 32'(obs), 32'({1'b1, 3'b001, 1'b1, 1'b0}));
    req = 3'b110; pat1 = 8'hF0; pat2 = 8'h0F;
    step();
    req = 3'b000;
    repeat (16) step();
    check("abort_slot4", 32'({obs, dbg_state}), 32'({1'b1, 3'b001, 1'b1, 1'b0, 2'd1}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_outputs", 32'({obs, dbg_state}), 32'(0));
    begin
      int activity = 0;
      for (int i = 0; i < 50; i++) begin
        step();
        if (obs != 6'b000000) activity++;
      end
      check("abort_no_activity", 32'(activity), 32'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
